// File: rtl/seq_detect_1101_moore.sv
// Moore FSM detecting the serial pattern 1101 with a saturating detection counter.
//
// Ports:
//   clk     - single clock, all state updates on the rising edge
//   rst     - asynchronous active-low reset (0 = reset asserted)
//   in      - serial data bit, sampled once per rising clk edge
//   dout    - detect flag, high for the one cycle the FSM sits in DETECT
//   det_cnt - number of detections since reset, saturates at all-ones
//
// Configuration macro:
//   SEQ_DETECT_OVERLAP_EN - when defined, the trailing '1' of a match is reused
//                           (DETECT --1--> S11); otherwise matches do not
//                           overlap (DETECT --1--> S1).
module seq_detect_1101_moore #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             dout,
    output logic [CNT_W-1:0] det_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S1     = 3'd1,
        S11    = 3'd2,
        S110   = 3'd3,
        DETECT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t next_state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = in ? S1     : IDLE;
            S1:      next_state = in ? S11    : IDLE;
            S11:     next_state = in ? S11    : S110;
            S110:    next_state = in ? DETECT : IDLE;
`ifdef SEQ_DETECT_OVERLAP_EN
            DETECT:  next_state = in ? S11    : IDLE;
`else
            DETECT:  next_state = in ? S1     : IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs: dout tracks the DETECT state exactly (a Moore decode
    // of the registered state), and the counter bumps on each edge entering DETECT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout    <= 1'b0;
            det_cnt <= '0;
        end else begin
            dout <= (next_state == DETECT);
            if ((next_state == DETECT) && (det_cnt != CNT_MAX)) begin
                det_cnt <= det_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_1101_moore.sv
// Directed self-checking bench for seq_detect_1101_moore (default CNT_W and CNT_W=2).
module tb_seq_detect_1101_moore;

    logic       clk;
    logic       rst;
    logic       in_bit;
    logic       dout;
    logic [7:0] det_cnt;
    logic       dout_s;
    logic [1:0] det_cnt_s;

    int errors = 0;
    int checks = 0;

    seq_detect_1101_moore dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in_bit),
        .dout    (dout),
        .det_cnt (det_cnt)
    );

    seq_detect_1101_moore #(.CNT_W(2)) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .in      (in_bit),
        .dout    (dout_s),
        .det_cnt (det_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit, let it be sampled, then settle 1 time unit past the edge.
    task automatic tick(input logic b);
        in_bit = b;
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge, release mid-cycle.
    task automatic do_reset();
        rst    = 1'b0;
        in_bit = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        in_bit = 1'b1;
        #2;
        checks++;
        if (dout !== 1'b0) begin
            errors++;
            $display("FAIL reset_dout: got %0b want 0", dout);
        end
        checks++;
        if (det_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", det_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 1'b0 || det_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_held: dout=%0b cnt=%0d want 0/0", dout, det_cnt);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        bit vin [4];
        bit vexp[4];
        vin  = '{1, 1, 0, 1};
        vexp = '{0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(vin[i]);
            checks++;
            if (dout !== vexp[i]) begin
                errors++;
                $display("FAIL basic_dout edge %0d: got %0b want %0b", i + 1, dout, vexp[i]);
            end
        end
        tick(1'b0);
        checks++;
        if (dout !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: got %0b want 0", dout);
        end
        checks++;
        if (det_cnt !== 8'd1) begin
            errors++;
            $display("FAIL basic_cnt: got %0d want 1", det_cnt);
        end
    endtask

    task automatic test_overlap();
        bit vin [7];
        bit vexp[7];
        logic [7:0] exp_cnt;
        vin = '{1, 1, 0, 1, 1, 0, 1};
`ifdef SEQ_DETECT_OVERLAP_EN
        vexp    = '{0, 0, 0, 1, 0, 0, 1};
        exp_cnt = 8'd2;
`else
        vexp    = '{0, 0, 0, 1, 0, 0, 0};
        exp_cnt = 8'd1;
`endif
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick(vin[i]);
            checks++;
            if (dout !== vexp[i]) begin
                errors++;
                $display("FAIL overlap_dout edge %0d: got %0b want %0b", i + 1, dout, vexp[i]);
            end
        end
        checks++;
        if (det_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL overlap_cnt: got %0d want %0d", det_cnt, exp_cnt);
        end
    endtask

    task automatic test_stream();
        bit vin [13];
        bit vexp[13];
        logic [7:0] exp_cnt;
        vin = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 1, 0, 1};
        // Without overlap the final 1101 shares its leading '1' with the
        // second match, so only two pulses occur.
`ifdef SEQ_DETECT_OVERLAP_EN
        vexp    = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
        exp_cnt = 8'd3;
`else
        vexp    = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        exp_cnt = 8'd2;
`endif
        do_reset();
        for (int i = 0; i < 13; i++) begin
            tick(vin[i]);
            checks++;
            if (dout !== vexp[i]) begin
                errors++;
                $display("FAIL stream_dout edge %0d: got %0b want %0b", i + 1, dout, vexp[i]);
            end
        end
        checks++;
        if (det_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL stream_cnt: got %0d want %0d", det_cnt, exp_cnt);
        end
    endtask

    task automatic test_near_miss();
        bit vin[9];
        vin = '{1, 0, 0, 1, 1, 1, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(vin[i]);
            checks++;
            if (dout !== 1'b0) begin
                errors++;
                $display("FAIL near_miss_dout edge %0d: got %0b want 0", i + 1, dout);
            end
        end
        checks++;
        if (det_cnt !== 8'd0) begin
            errors++;
            $display("FAIL near_miss_cnt: got %0d want 0", det_cnt);
        end
    endtask

    task automatic test_long_ones();
        bit vin[7];
        bit vexp[7];
        vin  = '{1, 1, 1, 1, 1, 0, 1};
        vexp = '{0, 0, 0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick(vin[i]);
            checks++;
            if (dout !== vexp[i]) begin
                errors++;
                $display("FAIL long_ones_dout edge %0d: got %0b want %0b", i + 1, dout, vexp[i]);
            end
        end
        checks++;
        if (det_cnt !== 8'd1) begin
            errors++;
            $display("FAIL long_ones_cnt: got %0d want 1", det_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        // Reset while in DETECT clears dout and count before any edge.
        tick(1); tick(1); tick(0); tick(1);
        checks++;
        if (dout !== 1'b1 || det_cnt !== 8'd1) begin
            errors++;
            $display("FAIL async_pre_detect: dout=%0b cnt=%0d want 1/1", dout, det_cnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dout !== 1'b0 || det_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_in_detect: dout=%0b cnt=%0d want 0/0", dout, det_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        // Reset while in S110: a following single '1' must not complete a match.
        tick(1); tick(1); tick(0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dout !== 1'b0) begin
            errors++;
            $display("FAIL async_in_s110: dout=%0b want 0", dout);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        tick(1);
        checks++;
        if (dout !== 1'b0) begin
            errors++;
            $display("FAIL async_aborted: dout=%0b want 0", dout);
        end
        tick(1); tick(0); tick(1);
        checks++;
        if (dout !== 1'b1 || det_cnt !== 8'd1) begin
            errors++;
            $display("FAIL async_fresh_detect: dout=%0b cnt=%0d want 1/1", dout, det_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            tick(1); tick(1); tick(0); tick(1);
            exp_cnt = (p >= 2) ? 2'd3 : 2'(p + 1);
            checks++;
            if (dout_s !== 1'b1 || det_cnt_s !== exp_cnt) begin
                errors++;
                $display("FAIL sat_pattern %0d: dout=%0b cnt=%0d want 1/%0d",
                         p + 1, dout_s, det_cnt_s, exp_cnt);
            end
        end
        tick(0);
        checks++;
        if (det_cnt_s !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold: got %0d want 3", det_cnt_s);
        end
    endtask

    initial begin
        rst    = 1'b0;
        in_bit = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_stream();
        test_near_miss();
        test_long_ones();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
